// File: rtl/core_pkg.sv
// Shared pipeline-control definitions for the 5-stage core: forward-select codes,
// hazard FSM state encoding and the default register address width.
package core_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LSTALL  = 2'd1,
    FLUSH   = 2'd2,
    MC_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/fwd_cmp.sv
// One ID operand's producer comparison: EX/MEM hit detection and the next
// forward-select code for the matching EX operand mux.
module fwd_cmp
  import core_pkg::*;
#(
  parameter int unsigned REG_AW = core_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_rs,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  output logic              hit_ex,
  output logic [1:0]        sel
);

  logic rs_live;
  logic hit_mem;

  // x0 is hardwired zero and never needs forwarding.
  assign rs_live = use_rs && (rs != '0);
  assign hit_ex  = rs_live && ex_regwrite  && (rs == ex_rd);
  assign hit_mem = rs_live && mem_regwrite && (rs == mem_rd);

  always_comb begin
    sel = FWD_RF;
    if (hit_ex && !ex_is_load) begin
      sel = FWD_MEM;
    end else if (hit_mem) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard/forwarding sequencer: registered EX forward selects plus the FSM that
// sequences load-use stalls, taken-branch flushes and multi-cycle EX waits.
module ex_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_AW       = core_pkg::REG_AW,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              ex_br_taken,
  input  logic              ex_mc_start,
  input  logic              mc_done,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic              hold_ex,
  output logic              mc_timeout_err,
  output logic [1:0]        state_o
);

  localparam int unsigned CNT_W = (MC_TIMEOUT > 4) ? $clog2(MC_TIMEOUT) : 2;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hit_ex_a;
  logic             hit_ex_b;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;
  logic             load_use;
  logic             id_advance;

  fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .rs           (id_rs1),
    .use_rs       (id_use_rs1),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .hit_ex       (hit_ex_a),
    .sel          (sel_a)
  );

  fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .rs           (id_rs2),
    .use_rs       (id_use_rs2),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_is_load   (ex_is_load),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .hit_ex       (hit_ex_b),
    .sel          (sel_b)
  );

  assign load_use = (hit_ex_a || hit_ex_b) && ex_is_load;

  // Pipeline controls act in the cycle the hazard is seen, so they decode
  // the current state and live inputs rather than being registered.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    hold_ex     = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_br_taken) begin
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (ex_mc_start) begin
          stall_pc = 1'b0;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
      end
      LSTALL: ;
      FLUSH: begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      MC_WAIT: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        hold_ex    = 1'b1;
      end
      default: ;
    endcase
  end

  assign id_advance = !stall_ifid && !hold_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      cnt            <= '0;
      fwd_a_sel      <= FWD_RF;
      fwd_b_sel      <= FWD_RF;
      mc_timeout_err <= 1'b0;
    end else begin
      if (id_advance) begin
        fwd_a_sel <= (bubble_idex || flush_ifid) ? FWD_RF : sel_a;
        fwd_b_sel <= (bubble_idex || flush_ifid) ? FWD_RF : sel_b;
      end
      unique case (state)
        RUN: begin
          if (ex_br_taken) begin
            // The RUN cycle is the first flush cycle; FLUSH covers the rest.
            cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (ex_mc_start) begin
            cnt   <= '0;
            state <= MC_WAIT;
          end else if (load_use) begin
            state <= LSTALL;
          end
        end
        LSTALL: state <= RUN;
        FLUSH: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RUN;
        end
        MC_WAIT: begin
          if (mc_done) begin
            state <= RUN;
          end else if (cnt == CNT_W'(MC_TIMEOUT - 1)) begin
            mc_timeout_err <= 1'b1;
            state          <= RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=16).
module tb_ex_hazard_ctrl;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic          id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite;
  logic          ex_br_taken, ex_mc_start, mc_done;
  logic [1:0]    fwd_a_sel, fwd_b_sel, state_o;
  logic          stall_pc, stall_ifid, bubble_idex, flush_ifid, hold_ex, mc_timeout_err;

  int total = 0;
  int bad   = 0;

  ex_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(2), .MC_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start), .mc_done(mc_done),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .hold_ex(hold_ex), .mc_timeout_err(mc_timeout_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0;
    ex_br_taken = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, "_stall_pc"}, {7'd0, stall_pc}, 8'd0);
    chk({tag, "_stall_ifid"}, {7'd0, stall_ifid}, 8'd0);
    chk({tag, "_bubble"}, {7'd0, bubble_idex}, 8'd0);
    chk({tag, "_flush"}, {7'd0, flush_ifid}, 8'd0);
    chk({tag, "_hold"}, {7'd0, hold_ex}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    cyc(); cyc();
    chk("rst_state", {6'd0, state_o}, 8'd0);
    chk("rst_fwd_a", {6'd0, fwd_a_sel}, 8'd0);
    chk("rst_fwd_b", {6'd0, fwd_b_sel}, 8'd0);
    chk("rst_err", {7'd0, mc_timeout_err}, 8'd0);
    chk_ctrl_zero("rst");
    rst_n = 1'b1;

    // EX forward on operand A
    ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; id_use_rs1 = 1;
    #1 chk("t1_stall", {7'd0, stall_pc}, 8'd0);
    cyc();
    chk("t1_fwd_a", {6'd0, fwd_a_sel}, 8'h1);
    chk("t1_fwd_b", {6'd0, fwd_b_sel}, 8'h0);
    // MEM forward on operand B
    clear_in();
    mem_rd = 9; mem_regwrite = 1; id_rs2 = 9; id_use_rs2 = 1;
    cyc();
    chk("t1b_fwd_b", {6'd0, fwd_b_sel}, 8'h2);
    chk("t1b_fwd_a", {6'd0, fwd_a_sel}, 8'h0);
    // EX beats MEM
    ex_rd = 9; ex_regwrite = 1;
    cyc();
    chk("t1c_fwd_b", {6'd0, fwd_b_sel}, 8'h1);
    // use bit low: no forward
    id_use_rs2 = 0;
    cyc();
    chk("t1d_fwd_b", {6'd0, fwd_b_sel}, 8'h0);
    clear_in();

    // Load-use stall then WB forward
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    #1;
    chk("t2_stall_pc", {7'd0, stall_pc}, 8'd1);
    chk("t2_stall_ifid", {7'd0, stall_ifid}, 8'd1);
    chk("t2_bubble", {7'd0, bubble_idex}, 8'd1);
    cyc();
    chk("t2_state_ls", {6'd0, state_o}, 8'd1);
    chk("t2_fwd_b_bub", {6'd0, fwd_b_sel}, 8'h0);
    ex_is_load = 0; ex_regwrite = 0; mem_rd = 7; mem_regwrite = 1;
    #1 chk_ctrl_zero("t2_ls");
    cyc();
    chk("t2_state_run", {6'd0, state_o}, 8'd0);
    chk("t2_fwd_b_wb", {6'd0, fwd_b_sel}, 8'h2);
    clear_in();

    // x0 never forwards nor stalls
    id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0; ex_regwrite = 1; ex_is_load = 1;
    mem_rd = 0; mem_regwrite = 1;
    #1 chk("t3_stall", {7'd0, stall_pc}, 8'd0);
    cyc();
    chk("t3_fwd_a", {6'd0, fwd_a_sel}, 8'h0);
    chk("t3_state", {6'd0, state_o}, 8'd0);
    clear_in();

    // Branch with simultaneous load-use: 2-cycle flush, no stall
    ex_is_load = 1; ex_regwrite = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    ex_br_taken = 1;
    #1;
    chk("t4_flush0", {7'd0, flush_ifid}, 8'd1);
    chk("t4_bubble0", {7'd0, bubble_idex}, 8'd1);
    chk("t4_stall0", {7'd0, stall_pc}, 8'd0);
    cyc();
    chk("t4_state_fl", {6'd0, state_o}, 8'd2);
    chk("t4_fwd_b", {6'd0, fwd_b_sel}, 8'h0);
    chk("t4_flush1", {7'd0, flush_ifid}, 8'd1);
    chk("t4_stall1", {7'd0, stall_pc}, 8'd0);
    cyc();
    clear_in();
    #1;
    chk("t4_state_run", {6'd0, state_o}, 8'd0);
    chk("t4_flush2", {7'd0, flush_ifid}, 8'd0);

    // Multi-cycle op completing after 10 hold cycles
    ex_mc_start = 1;
    #1 chk("t5_hold_run", {7'd0, hold_ex}, 8'd0);
    cyc();
    ex_mc_start = 0;
    chk("t5_stall_pc", {7'd0, stall_pc}, 8'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) mc_done = 1;
      #1 chk("t5_hold", {7'd0, hold_ex}, 8'd1);
      cyc();
    end
    mc_done = 0;
    #1;
    chk("t5_hold_end", {7'd0, hold_ex}, 8'd0);
    chk("t5_state", {6'd0, state_o}, 8'd0);
    chk("t5_err0", {7'd0, mc_timeout_err}, 8'd0);

    // mc_done on the timeout cycle: done wins, no error
    ex_mc_start = 1;
    cyc();
    ex_mc_start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) mc_done = 1;
      cyc();
    end
    mc_done = 0;
    chk("t5b_state", {6'd0, state_o}, 8'd0);
    chk("t5b_err", {7'd0, mc_timeout_err}, 8'd0);

    // No mc_done: timeout after 16 cycles
    ex_mc_start = 1;
    cyc();
    ex_mc_start = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("t5c_state_wait", {6'd0, state_o}, 8'd3);
        chk("t5c_err_pre", {7'd0, mc_timeout_err}, 8'd0);
      end
      cyc();
    end
    chk("t5c_state", {6'd0, state_o}, 8'd0);
    chk("t5c_err", {7'd0, mc_timeout_err}, 8'd1);
    chk("t5c_hold", {7'd0, hold_ex}, 8'd0);
    cyc();
    chk("t5c_err_sticky", {7'd0, mc_timeout_err}, 8'd1);

    // Reset during MC_WAIT
    ex_mc_start = 1;
    cyc();
    ex_mc_start = 0;
    cyc();
    chk("t6_hold_pre", {7'd0, hold_ex}, 8'd1);
    rst_n = 0;
    cyc();
    chk("t6_state", {6'd0, state_o}, 8'd0);
    chk("t6_err", {7'd0, mc_timeout_err}, 8'd0);
    chk("t6_fwd_a", {6'd0, fwd_a_sel}, 8'd0);
    chk("t6_fwd_b", {6'd0, fwd_b_sel}, 8'd0);
    chk_ctrl_zero("t6");
    rst_n = 1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
